// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port integer register file with a per-register scoreboard.
// ID issues writers, which marks the destination busy under a producer tag.
// WB writes data back and clears busy only when its tag matches the current owner.
// Register 0 reads as zero and is never busy.
//
// Ports:
//   dclk, rst_n          clock, synchronous active-low reset
//   re_i/raddr_i         per-port read enable / address (port k at [k*AW +: AW])
//   rdata_o/rbusy_o      per-port read data / busy flag (combinational)
//   iss_i/iss_rd_i/iss_tag_i   issue strobe, destination, producer tag
//   we_i/waddr_i/wdata_i/wtag_i writeback enable, address, data, producer tag
//   flush_i              clear every busy bit, data is kept
//   dbg_o                committed value of regs[DBG_IDX], never bypassed
//
// Build option: define WB_BYPASS_EN to forward a same-cycle writeback to reads.

module regfile_sb #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NREG    = 32,
  parameter int unsigned AW      = $clog2(NREG),
  parameter int unsigned NRD     = 2,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned DBG_IDX = 1
) (
  input  logic                  dclk,
  input  logic                  rst_n,
  input  logic [NRD-1:0]        re_i,
  input  logic [NRD*AW-1:0]     raddr_i,
  output logic [NRD*DATA_W-1:0] rdata_o,
  output logic [NRD-1:0]        rbusy_o,
  input  logic                  iss_i,
  input  logic [AW-1:0]         iss_rd_i,
  input  logic [TAG_W-1:0]      iss_tag_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [TAG_W-1:0]      wtag_i,
  input  logic                  flush_i,
  output logic [DATA_W-1:0]     dbg_o
);

  logic [DATA_W-1:0] regs [NREG];
  logic [TAG_W-1:0]  tags [NREG];
  logic [NREG-1:0]   busy;

  logic wb_ok;
  logic wb_clr;
  logic iss_ok;

  assign wb_ok  = we_i && (waddr_i != '0);
  assign wb_clr = wb_ok && busy[waddr_i] && (tags[waddr_i] == wtag_i);
  assign iss_ok = iss_i && (iss_rd_i != '0);

  // State update; the issue assignment comes after the clear so issue wins on the same register.
  always_ff @(posedge dclk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
        tags[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (wb_ok) regs[waddr_i] <= wdata_i;
      if (flush_i) begin
        busy <= '0;
      end else begin
        if (wb_clr) busy[waddr_i] <= 1'b0;
        if (iss_ok) begin
          busy[iss_rd_i] <= 1'b1;
          tags[iss_rd_i] <= iss_tag_i;
        end
      end
    end
  end

  // Independent zero-latency read ports.
  for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
    logic [AW-1:0]     a;
    logic [DATA_W-1:0] d;
    logic              b;

    assign a = raddr_i[k*AW +: AW];

    always_comb begin
      d = '0;
      b = 1'b0;
      if (rst_n && re_i[k] && (a != '0)) begin
        d = regs[a];
        b = busy[a];
`ifdef WB_BYPASS_EN
        // Forward the in-flight writeback, showing busy as it will be after the tag clear.
        if (we_i && (waddr_i == a)) begin
          d = wdata_i;
          b = busy[a] & ~(tags[a] == wtag_i);
        end
`endif
      end
    end

    assign rdata_o[k*DATA_W +: DATA_W] = d;
    assign rbusy_o[k]                  = b;
  end

  assign dbg_o = regs[AW'(DBG_IDX)];

endmodule

// File: tb/tb_regfile_sb.sv
// Directed vector bench for regfile_sb (2 read ports, DBG_IDX=1).
// Each vector drives inputs for one cycle and checks the combinational
// outputs just before the next rising edge.

module tb_regfile_sb;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        dclk;
  logic        rst_n;
  logic [1:0]  re_i;
  logic [9:0]  raddr_i;
  logic [63:0] rdata_o;
  logic [1:0]  rbusy_o;
  logic        iss_i;
  logic [4:0]  iss_rd_i;
  logic [3:0]  iss_tag_i;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [3:0]  wtag_i;
  logic        flush_i;
  logic [31:0] dbg_o;

  regfile_sb dut (
    .dclk(dclk), .rst_n(rst_n), .re_i(re_i), .raddr_i(raddr_i),
    .rdata_o(rdata_o), .rbusy_o(rbusy_o), .iss_i(iss_i), .iss_rd_i(iss_rd_i),
    .iss_tag_i(iss_tag_i), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .wtag_i(wtag_i), .flush_i(flush_i), .dbg_o(dbg_o)
  );

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  typedef struct {
    logic        rst;
    logic [1:0]  re;
    logic [4:0]  a0, a1;
    logic        iss;
    logic [4:0]  ird;
    logic [3:0]  itag;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  wt;
    logic        fl;
    logic [31:0] d0, d1;
    logic        b0, b1;
    logic [31:0] dbg;
  } vec_t;

  localparam int NV = 21;
  vec_t v [NV];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(input logic rst, input logic [1:0] re,
                              input logic [4:0] a0, input logic [4:0] a1,
                              input logic iss, input logic [4:0] ird, input logic [3:0] itag,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [3:0] wt, input logic fl,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic b0, input logic b1, input logic [31:0] dbg);
    vec_t r;
    r.rst = rst; r.re = re; r.a0 = a0; r.a1 = a1;
    r.iss = iss; r.ird = ird; r.itag = itag;
    r.we = we; r.wa = wa; r.wd = wd; r.wt = wt; r.fl = fl;
    r.d0 = d0; r.d1 = d1; r.b0 = b0; r.b1 = b1; r.dbg = dbg;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step%0d: got 0x%08h want 0x%08h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    rst_n = x.rst; re_i = x.re; raddr_i = {x.a1, x.a0};
    iss_i = x.iss; iss_rd_i = x.ird; iss_tag_i = x.itag;
    we_i = x.we; waddr_i = x.wa; wdata_i = x.wd; wtag_i = x.wt; flush_i = x.fl;
  endtask

  task automatic check(input vec_t x, input int idx);
    chk("rdata0", idx, rdata_o[31:0], x.d0);
    chk("rdata1", idx, rdata_o[63:32], x.d1);
    chk("rbusy0", idx, 32'(rbusy_o[0]), 32'(x.b0));
    chk("rbusy1", idx, 32'(rbusy_o[1]), 32'(x.b1));
    chk("dbg", idx, dbg_o, x.dbg);
  endtask

  initial begin
    vec_t idle;
    //       rst re  a0 a1  iss rd tag  we wa wdata        wt fl  d0 / d1 / b0 b1 / dbg
    v[0]  = mk(0, 3, 3, 3,  0, 0, 0,   0, 0, 0,           0, 0,  0, 0, 0, 0, 0);
    v[1]  = mk(0, 3, 3, 3,  0, 0, 0,   0, 0, 0,           0, 0,  0, 0, 0, 0, 0);
    v[2]  = mk(1, 3, 3, 5,  1, 5, 2,   0, 0, 0,           0, 0,  0, 0, 0, 0, 0);
    v[3]  = mk(1, 3, 5, 5,  0, 0, 0,   1, 5, 32'hDEADBEEF, 2, 0,
               BYP ? 32'hDEADBEEF : 0, BYP ? 32'hDEADBEEF : 0, !BYP, !BYP, 0);
    v[4]  = mk(1, 3, 5, 5,  1, 7, 1,   0, 0, 0,           0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
    v[5]  = mk(1, 3, 7, 5,  1, 7, 3,   0, 0, 0,           0, 0,  0, 32'hDEADBEEF, 1, 0, 0);
    v[6]  = mk(1, 3, 7, 7,  0, 0, 0,   1, 7, 32'h11,      1, 0,
               BYP ? 32'h11 : 0, BYP ? 32'h11 : 0, 1, 1, 0);
    v[7]  = mk(1, 3, 7, 7,  0, 0, 0,   1, 7, 32'h33,      3, 0,
               BYP ? 32'h33 : 32'h11, BYP ? 32'h33 : 32'h11, !BYP, !BYP, 0);
    v[8]  = mk(1, 3, 7, 9,  1, 9, 4,   1, 9, 32'h55,      0, 0,  32'h33, BYP ? 32'h55 : 0, 0, 0, 0);
    v[9]  = mk(1, 3, 0, 9,  0, 0, 0,   1, 0, 32'hFFFF,    0, 0,  0, 32'h55, 0, 1, 0);
    v[10] = mk(1, 1, 0, 9,  0, 0, 0,   1, 1, 32'h1234,    0, 0,  0, 0, 0, 0, 0);
    v[11] = mk(1, 3, 1, 1,  1, 1, 1,   0, 0, 0,           0, 0,  32'h1234, 32'h1234, 0, 0, 32'h1234);
    v[12] = mk(1, 3, 1, 2,  1, 2, 1,   0, 0, 0,           0, 0,  32'h1234, 0, 1, 0, 32'h1234);
    v[13] = mk(1, 3, 2, 1,  1, 3, 1,   0, 0, 0,           0, 0,  0, 32'h1234, 1, 1, 32'h1234);
    v[14] = mk(1, 3, 3, 1,  1, 4, 1,   0, 0, 0,           0, 0,  0, 32'h1234, 1, 1, 32'h1234);
    v[15] = mk(1, 3, 4, 2,  1, 2, 5,   0, 0, 0,           0, 1,  0, 0, 1, 1, 32'h1234);
    v[16] = mk(1, 3, 1, 2,  0, 0, 0,   0, 0, 0,           0, 0,  32'h1234, 0, 0, 0, 32'h1234);
    v[17] = mk(1, 3, 6, 3,  0, 0, 0,   1, 6, 32'hA5A5,    0, 0,  BYP ? 32'hA5A5 : 0, 0, 0, 0, 32'h1234);
    v[18] = mk(1, 3, 6, 9,  1, 6, 2,   0, 0, 0,           0, 0,  32'hA5A5, 32'h55, 0, 0, 32'h1234);
    v[19] = mk(0, 3, 6, 4,  1, 6, 3,   1, 6, 1,           2, 1,  0, 0, 0, 0, 32'h1234);
    v[20] = mk(1, 3, 6, 1,  0, 0, 0,   0, 0, 0,           0, 0,  0, 0, 0, 0, 0);

    idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(v[0]);

    for (int i = 0; i < NV; i++) begin
      @(negedge dclk);
      drive(v[i]);
      #2;
      check(v[i], i);
    end

    // Per-port enable independence and same address on both ports.
    @(negedge dclk);
    drive(idle);
    we_i = 1'b1; waddr_i = 5'd10; wdata_i = 32'hCAFE;
    @(negedge dclk);
    drive(idle);
    re_i = 2'b01; raddr_i = {5'd10, 5'd10};
    #2;
    chk("re_split_d0", 100, rdata_o[31:0], 32'hCAFE);
    chk("re_split_d1", 100, rdata_o[63:32], 32'h0);
    re_i = 2'b11;
    #1;
    chk("same_addr_d0", 101, rdata_o[31:0], 32'hCAFE);
    chk("same_addr_d1", 101, rdata_o[63:32], 32'hCAFE);

    // Tag mismatch on a non-busy register still writes data and leaves busy clear.
    @(negedge dclk);
    drive(idle);
    we_i = 1'b1; waddr_i = 5'd10; wdata_i = 32'hBEEF; wtag_i = 4'd7;
    @(negedge dclk);
    drive(idle);
    re_i = 2'b11; raddr_i = {5'd10, 5'd10};
    #2;
    chk("wb_nobusy_d", 102, rdata_o[31:0], 32'hBEEF);
    chk("wb_nobusy_b", 102, 32'(rbusy_o[0]), 32'h0);

    @(negedge dclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
